memory_unit: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes its EM_* pipeline register outputs and produces the MW_* register that feeds writeback and the execute-stage forwarding path.
- Load data is read from data memory during execute; this stage aligns and extends it.
- This stage owns the data-memory write port (stores, AMO write-back) with a req/ready handshake and a watchdog.
- It also drives the CSR write port and raises a stall while a write is outstanding.

---
 rtl/memory_unit.sv | 196 +++++++++++++++++++
 tb/tb_memory_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// memory_unit: memory pipeline stage. It aligns load data and owns the data-memory
// write port, which has a req/ready handshake and a watchdog. It drives the CSR write
// port and holds the MW register that feeds writeback and forwarding.
module memory_unit #(
  parameter int unsigned MAX_WAIT = 255,
  parameter logic [31:0] BOX      = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        M_stall_i,
  input  logic        W_flush_i,
  input  logic [31:0] EM_PC_i,
  input  logic [31:0] EM_instr_i,
  input  logic        EM_nop_i,
  input  logic        EM_isLoad_i,
  input  logic        EM_isStore_i,
  input  logic        EM_isCSR_i,
  input  logic        EM_isCSRWrite_i,
  input  logic        EM_isAMO_i,
  input  logic [5:0]  EM_rdId_i,
  input  logic [11:0] EM_csrId_i,
  input  logic [2:0]  EM_funct3_i,
  input  logic [63:0] EM_rs2_i,
  input  logic [63:0] EM_Eresult_i,
  input  logic [31:0] EM_addr_i,
  input  logic [63:0] EM_Mdata_i,
  input  logic [31:0] EM_CSRdata_i,
  input  logic        EM_wbEnable_i,
  output logic [31:0] DMemWAddr_o,
  output logic [63:0] DMemWData_o,
  output logic [7:0]  DMemWMask_o,
  output logic        DMemWReq_o,
  input  logic        DMemWReady_i,
  output logic        csrWEnable_o,
  output logic [11:0] csrWAddr_o,
  output logic [31:0] csrWData_o,
  output logic        M_stall_o,
  output logic        M_fault_o,
  output logic [31:0] MW_PC_o,
  output logic [31:0] MW_instr_o,
  output logic        MW_nop_o,
  output logic [5:0]  MW_rdId_o,
  output logic [63:0] MW_wbData_o,
  output logic        MW_wbEnable_o
);

  localparam logic [31:0] NOP_INSTR  = 32'h00000033;
  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [15:0] cnt;

  logic        valid;
  logic        wr;
  logic [2:0]  offset;
  logic        wait_expired;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  logic [63:0] load_data;
  logic [63:0] wb_data;

  assign valid        = !EM_nop_i;
  assign wr           = valid && (EM_isStore_i || EM_isAMO_i);
  assign offset       = EM_addr_i[2:0];
  assign wait_expired = (state == WAIT) && (cnt == MAX_WAIT_C);

  assign DMemWAddr_o  = {EM_addr_i[31:3], 3'b000};
  assign DMemWReq_o   = wr && (state != DONE) && !reset_i;
  assign M_stall_o    = DMemWReq_o && !DMemWReady_i && !wait_expired;

  assign csrWEnable_o = valid && EM_isCSRWrite_i && !M_stall_o && !M_stall_i;
  assign csrWAddr_o   = EM_csrId_i;
  assign csrWData_o   = EM_Eresult_i[31:0];

  // Select the addressed lane of the doubleword and extend it; sub-size offset bits are ignored
  always_comb begin
    ld_byte = EM_Mdata_i[{offset, 3'b000} +: 8];
    ld_half = EM_Mdata_i[{offset[2:1], 4'b0000} +: 16];
    ld_word = offset[2] ? EM_Mdata_i[63:32] : EM_Mdata_i[31:0];
    case (EM_funct3_i)
      3'b000:  load_data = {BOX, {24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {BOX, 24'h000000, ld_byte};
      3'b001:  load_data = {BOX, {16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {BOX, 16'h0000, ld_half};
      3'b011:  load_data = EM_Mdata_i;
      default: load_data = {BOX, ld_word};
    endcase
  end

  // Byte enables and lane-replicated write data; AMOs always write a word
  always_comb begin
    if (EM_isAMO_i) begin
      DMemWMask_o = 8'h0F << {offset[2], 2'b00};
      DMemWData_o = {2{EM_Eresult_i[31:0]}};
    end else begin
      case (EM_funct3_i[1:0])
        2'b00: begin
          DMemWMask_o = 8'h01 << offset;
          DMemWData_o = {8{EM_rs2_i[7:0]}};
        end
        2'b01: begin
          DMemWMask_o = 8'h03 << {offset[2:1], 1'b0};
          DMemWData_o = {4{EM_rs2_i[15:0]}};
        end
        2'b10: begin
          DMemWMask_o = 8'h0F << {offset[2], 2'b00};
          DMemWData_o = {2{EM_rs2_i[31:0]}};
        end
        default: begin
          DMemWMask_o = 8'hFF;
          DMemWData_o = EM_rs2_i;
        end
      endcase
    end
  end

  // Writeback value priority: load, AMO old memory word, old CSR value, execute result
  always_comb begin
    if (EM_isLoad_i)       wb_data = load_data;
    else if (EM_isAMO_i)   wb_data = {BOX, ld_word};
    else if (EM_isCSR_i)   wb_data = {BOX, EM_CSRdata_i};
    else                   wb_data = EM_Eresult_i;
  end

  // Write handshake; DONE keeps a store held by M_stall_i from being written twice
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      M_fault_o <= 1'b0;
    end else begin
      M_fault_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wr) begin
            if (DMemWReady_i) begin
              state <= M_stall_i ? DONE : IDLE;
            end else begin
              state <= WAIT;
              cnt   <= 16'd1;
            end
          end
        end
        WAIT: begin
          if (!wr) begin
            state <= IDLE;
          end else if (DMemWReady_i) begin
            state <= M_stall_i ? DONE : IDLE;
          end else if (cnt == MAX_WAIT_C) begin
            M_fault_o <= 1'b1;
            state     <= M_stall_i ? DONE : IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          if (!M_stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MW register: capture when free, bubble while the write stalls, flush overrides both
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      MW_PC_o       <= 32'd0;
      MW_instr_o    <= NOP_INSTR;
      MW_nop_o      <= 1'b1;
      MW_rdId_o     <= 6'd0;
      MW_wbData_o   <= 64'd0;
      MW_wbEnable_o <= 1'b0;
    end else begin
      if (!M_stall_i && !M_stall_o) begin
        MW_PC_o       <= EM_PC_i;
        MW_instr_o    <= EM_instr_i;
        MW_nop_o      <= EM_nop_i;
        MW_rdId_o     <= EM_rdId_i;
        MW_wbData_o   <= wb_data;
        MW_wbEnable_o <= valid && EM_wbEnable_i && (EM_rdId_i != 6'd0);
      end else if (!M_stall_i && M_stall_o) begin
        MW_nop_o      <= 1'b1;
        MW_wbEnable_o <= 1'b0;
      end
      if (W_flush_i) begin
        MW_nop_o      <= 1'b1;
        MW_wbEnable_o <= 1'b0;
        MW_instr_o    <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: table vectors, randomized instructions against a reference model,
// and hand-written sequences for the handshake, hold, watchdog and flush cases.
module tb_memory_unit;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_CSR = 3, K_AMO = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        nop;
    int          kind;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] mdata;
    logic [63:0] rs2;
    logic [63:0] eres;
    logic [31:0] csrdata;
    logic [11:0] csrid;
    logic [5:0]  rd;
    logic        wben;
  } instr_t;

  typedef struct {
    instr_t      t;
    logic [63:0] wb;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } vec_t;

  logic        clk_i, reset_i, M_stall_i, W_flush_i;
  logic [31:0] EM_PC_i, EM_instr_i, EM_addr_i, EM_CSRdata_i;
  logic        EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_isCSRWrite_i, EM_isAMO_i;
  logic [5:0]  EM_rdId_i;
  logic [11:0] EM_csrId_i;
  logic [2:0]  EM_funct3_i;
  logic [63:0] EM_rs2_i, EM_Eresult_i, EM_Mdata_i;
  logic        EM_wbEnable_i;
  logic [31:0] DMemWAddr_o;
  logic [63:0] DMemWData_o;
  logic [7:0]  DMemWMask_o;
  logic        DMemWReq_o, DMemWReady_i;
  logic        csrWEnable_o;
  logic [11:0] csrWAddr_o;
  logic [31:0] csrWData_o;
  logic        M_stall_o, M_fault_o;
  logic [31:0] MW_PC_o, MW_instr_o;
  logic        MW_nop_o;
  logic [5:0]  MW_rdId_o;
  logic [63:0] MW_wbData_o;
  logic        MW_wbEnable_o;

  int     checks;
  int     errors;
  int     stallCycles, accepts, faults, reqLate;
  logic   stalled, done;
  vec_t   vecs[$];
  instr_t cur, alu;
  logic [2:0] loadF3 [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
  logic [2:0] f3;
  int     kind;

  memory_unit #(.MAX_WAIT(4), .BOX(32'hFFFFFFFF)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .M_stall_i(M_stall_i), .W_flush_i(W_flush_i),
    .EM_PC_i(EM_PC_i), .EM_instr_i(EM_instr_i), .EM_nop_i(EM_nop_i),
    .EM_isLoad_i(EM_isLoad_i), .EM_isStore_i(EM_isStore_i), .EM_isCSR_i(EM_isCSR_i),
    .EM_isCSRWrite_i(EM_isCSRWrite_i), .EM_isAMO_i(EM_isAMO_i), .EM_rdId_i(EM_rdId_i),
    .EM_csrId_i(EM_csrId_i), .EM_funct3_i(EM_funct3_i), .EM_rs2_i(EM_rs2_i),
    .EM_Eresult_i(EM_Eresult_i), .EM_addr_i(EM_addr_i), .EM_Mdata_i(EM_Mdata_i),
    .EM_CSRdata_i(EM_CSRdata_i), .EM_wbEnable_i(EM_wbEnable_i),
    .DMemWAddr_o(DMemWAddr_o), .DMemWData_o(DMemWData_o), .DMemWMask_o(DMemWMask_o),
    .DMemWReq_o(DMemWReq_o), .DMemWReady_i(DMemWReady_i),
    .csrWEnable_o(csrWEnable_o), .csrWAddr_o(csrWAddr_o), .csrWData_o(csrWData_o),
    .M_stall_o(M_stall_o), .M_fault_o(M_fault_o),
    .MW_PC_o(MW_PC_o), .MW_instr_o(MW_instr_o), .MW_nop_o(MW_nop_o),
    .MW_rdId_o(MW_rdId_o), .MW_wbData_o(MW_wbData_o), .MW_wbEnable_o(MW_wbEnable_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic instr_t make_instr(int kind, logic [2:0] f3, logic [31:0] addr,
                                        logic [63:0] mdata, logic [63:0] rs2, logic [63:0] eres,
                                        logic [31:0] csrdata, logic [11:0] csrid, logic [5:0] rd,
                                        logic wben, logic [31:0] pc);
    instr_t t;
    t.pc = pc; t.instr = pc ^ 32'h00A0_0013; t.nop = 1'b0; t.kind = kind; t.funct3 = f3;
    t.addr = addr; t.mdata = mdata; t.rs2 = rs2; t.eres = eres; t.csrdata = csrdata;
    t.csrid = csrid; t.rd = rd; t.wben = wben;
    return t;
  endfunction

  // Reference model: size = 2^funct3[1:0] bytes, naturally aligned inside the doubleword
  function automatic logic [63:0] modelLoad(logic [2:0] f3, logic [2:0] o, logic [63:0] md);
    int nbytes;
    int start;
    logic [63:0] raw;
    logic [63:0] lowMask;
    nbytes = 1 << f3[1:0];
    if (nbytes == 8) return md;
    start   = (int'(o) / nbytes) * nbytes;
    raw     = md >> (start * 8);
    lowMask = (64'd1 << (nbytes * 8)) - 64'd1;
    raw     = raw & lowMask;
    if (!f3[2] && raw[nbytes * 8 - 1]) raw = raw | ~lowMask;
    return {32'hFFFFFFFF, raw[31:0]};
  endfunction

  function automatic logic [63:0] modelWb(instr_t t);
    logic [63:0] w;
    if (t.kind == K_LOAD)     return modelLoad(t.funct3, t.addr[2:0], t.mdata);
    else if (t.kind == K_AMO) begin
      w = t.mdata >> (t.addr[2] ? 32 : 0);
      return {32'hFFFFFFFF, w[31:0]};
    end
    else if (t.kind == K_CSR) return {32'hFFFFFFFF, t.csrdata};
    else                      return t.eres;
  endfunction

  function automatic logic [7:0] modelMask(instr_t t);
    int nbytes;
    int start;
    nbytes = (t.kind == K_AMO) ? 4 : (1 << t.funct3[1:0]);
    start  = (int'(t.addr[2:0]) / nbytes) * nbytes;
    return 8'(((1 << nbytes) - 1) << start);
  endfunction

  function automatic logic [63:0] modelWdata(instr_t t);
    int nbytes;
    logic [63:0] src;
    logic [63:0] d;
    nbytes = (t.kind == K_AMO) ? 4 : (1 << t.funct3[1:0]);
    src    = (t.kind == K_AMO) ? t.eres : t.rs2;
    d      = 64'd0;
    for (int k = 0; k < 8; k++) d[k * 8 +: 8] = src[(k % nbytes) * 8 +: 8];
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic driveNop();
    EM_nop_i = 1'b1; EM_isLoad_i = 1'b0; EM_isStore_i = 1'b0; EM_isCSR_i = 1'b0;
    EM_isCSRWrite_i = 1'b0; EM_isAMO_i = 1'b0; EM_wbEnable_i = 1'b0;
    EM_PC_i = 32'd0; EM_instr_i = 32'h00000033; EM_rdId_i = 6'd0; EM_csrId_i = 12'd0;
    EM_funct3_i = 3'd0; EM_rs2_i = 64'd0; EM_Eresult_i = 64'd0; EM_addr_i = 32'd0;
    EM_Mdata_i = 64'd0; EM_CSRdata_i = 32'd0;
  endtask

  task automatic applyStimulus(input instr_t t, input logic ready, input logic stall, input logic flush);
    @(negedge clk_i);
    EM_PC_i = t.pc; EM_instr_i = t.instr; EM_nop_i = t.nop;
    EM_isLoad_i = (t.kind == K_LOAD); EM_isStore_i = (t.kind == K_STORE);
    EM_isCSR_i = (t.kind == K_CSR); EM_isCSRWrite_i = (t.kind == K_CSR);
    EM_isAMO_i = (t.kind == K_AMO); EM_rdId_i = t.rd; EM_csrId_i = t.csrid;
    EM_funct3_i = t.funct3; EM_rs2_i = t.rs2; EM_Eresult_i = t.eres; EM_addr_i = t.addr;
    EM_Mdata_i = t.mdata; EM_CSRdata_i = t.csrdata; EM_wbEnable_i = t.wben;
    DMemWReady_i = ready; M_stall_i = stall; W_flush_i = flush;
  endtask

  // One instruction with an immediately-ready memory: check the write/CSR ports, then MW
  task automatic checkInstr(input instr_t t, input logic [63:0] expWb, input logic [7:0] expMask,
                            input logic [63:0] expWdata, input string tag);
    logic wrExp, csrExp;
    applyStimulus(t, 1'b1, 1'b0, 1'b0);
    #1;
    wrExp  = !t.nop && (t.kind == K_STORE || t.kind == K_AMO);
    csrExp = !t.nop && (t.kind == K_CSR);
    checkOutput({tag, "_req"}, 64'(DMemWReq_o), 64'(wrExp));
    checkOutput({tag, "_stall"}, 64'(M_stall_o), 64'd0);
    if (wrExp) begin
      checkOutput({tag, "_waddr"}, 64'(DMemWAddr_o), 64'({t.addr[31:3], 3'b000}));
      checkOutput({tag, "_wmask"}, 64'(DMemWMask_o), 64'(expMask));
      checkOutput({tag, "_wdata"}, DMemWData_o, expWdata);
    end
    checkOutput({tag, "_csren"}, 64'(csrWEnable_o), 64'(csrExp));
    if (csrExp) begin
      checkOutput({tag, "_csraddr"}, 64'(csrWAddr_o), 64'(t.csrid));
      checkOutput({tag, "_csrdata"}, 64'(csrWData_o), 64'(t.eres[31:0]));
    end
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_mwpc"}, 64'(MW_PC_o), 64'(t.pc));
    checkOutput({tag, "_mwinstr"}, 64'(MW_instr_o), 64'(t.instr));
    checkOutput({tag, "_mwnop"}, 64'(MW_nop_o), 64'(t.nop));
    checkOutput({tag, "_mwrd"}, 64'(MW_rdId_o), 64'(t.rd));
    checkOutput({tag, "_mwdata"}, MW_wbData_o, expWb);
    checkOutput({tag, "_mwwben"}, 64'(MW_wbEnable_o), 64'(!t.nop && t.wben && (t.rd != 6'd0)));
  endtask

  task automatic addVec(input instr_t t, input logic [63:0] wb, input logic [7:0] mask, input logic [63:0] wdata);
    vec_t v;
    v.t = t; v.wb = wb; v.mask = mask; v.wdata = wdata;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    driveNop();
    reset_i = 1'b1; M_stall_i = 1'b0; W_flush_i = 1'b0; DMemWReady_i = 1'b0;

    // Table: kind, f3, addr, mdata, rs2, eres, csrdata, csrid, rd, wben, pc
    addVec(make_instr(K_LOAD, 3'b000, 32'h1003, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 6'd5, 1'b1, 32'h100),
           64'hFFFFFFFF_FFFFFF80, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b100, 32'h1003, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 6'd5, 1'b1, 32'h104),
           64'hFFFFFFFF_00000080, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b101, 32'h1006, 64'hBEEF_0000_0000_0000, 0, 0, 0, 0, 6'd7, 1'b1, 32'h108),
           64'hFFFFFFFF_0000BEEF, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b001, 32'h1002, 64'h0000_0000_8001_0000, 0, 0, 0, 0, 6'd8, 1'b1, 32'h10C),
           64'hFFFFFFFF_FFFF8001, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b010, 32'h1004, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 6'd9, 1'b1, 32'h110),
           64'hFFFFFFFF_12345678, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b011, 32'h1000, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 6'h21, 1'b1, 32'h114),
           64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);
    addVec(make_instr(K_LOAD, 3'b000, 32'h1000, 64'h0000_0000_0000_007F, 0, 0, 0, 0, 6'd3, 1'b1, 32'h118),
           64'hFFFFFFFF_0000007F, 8'h00, 64'h0);
    addVec(make_instr(K_STORE, 3'b001, 32'h2006, 0, 64'h1234, 0, 0, 0, 6'd0, 1'b0, 32'h11C),
           64'h0, 8'hC0, 64'h1234_1234_1234_1234);
    addVec(make_instr(K_STORE, 3'b000, 32'h2005, 0, 64'hAB, 0, 0, 0, 6'd0, 1'b0, 32'h120),
           64'h0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB);
    addVec(make_instr(K_STORE, 3'b010, 32'h2004, 0, 64'hDEADBEEF, 0, 0, 0, 6'd0, 1'b0, 32'h124),
           64'h0, 8'hF0, 64'hDEADBEEF_DEADBEEF);
    addVec(make_instr(K_STORE, 3'b011, 32'h2000, 0, 64'h1122_3344_5566_7788, 0, 0, 0, 6'd0, 1'b0, 32'h128),
           64'h0, 8'hFF, 64'h1122_3344_5566_7788);
    addVec(make_instr(K_CSR, 3'b001, 32'h0, 0, 0, 64'h5, 32'hA, 12'h300, 6'd5, 1'b1, 32'h12C),
           64'hFFFFFFFF_0000000A, 8'h00, 64'h0);
    addVec(make_instr(K_ALU, 3'b000, 32'h0, 0, 0, 64'h55, 0, 0, 6'd0, 1'b1, 32'h130),
           64'h55, 8'h00, 64'h0);
    addVec(make_instr(K_AMO, 3'b010, 32'h3004, 64'h0000_0007_0000_0003, 0, 64'h9, 0, 0, 6'd6, 1'b1, 32'h134),
           64'hFFFFFFFF_00000007, 8'hF0, 64'h0000_0009_0000_0009);

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_nop", 64'(MW_nop_o), 64'd1);
    checkOutput("rst_wben", 64'(MW_wbEnable_o), 64'd0);
    checkOutput("rst_instr", 64'(MW_instr_o), 64'h33);
    checkOutput("rst_pc", 64'(MW_PC_o), 64'd0);
    checkOutput("rst_rd", 64'(MW_rdId_o), 64'd0);
    checkOutput("rst_data", MW_wbData_o, 64'd0);
    checkOutput("rst_fault", 64'(M_fault_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      checkInstr(vecs[i].t, vecs[i].wb, vecs[i].mask, vecs[i].wdata, $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        K_LOAD:  f3 = loadF3[$urandom_range(0, 5)];
        K_STORE: f3 = {1'b0, 2'($urandom_range(0, 3))};
        K_AMO:   f3 = 3'b010;
        default: f3 = 3'($urandom);
      endcase
      cur = make_instr(kind, f3, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom, 12'($urandom), 6'($urandom),
                       1'($urandom), $urandom);
      if ($urandom_range(0, 9) == 0) cur.nop = 1'b1;
      checkInstr(cur, modelWb(cur), modelMask(cur), modelWdata(cur), $sformatf("rnd%0d", i));
    end

    // SW with ready delayed three cycles: three stalled bubbles then the store retires
    cur = make_instr(K_STORE, 3'b010, 32'h3004, 0, 64'hCAFEF00D, 0, 0, 0, 6'd0, 1'b0, 32'h400);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    stallCycles = 0; accepts = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      DMemWReady_i = (c >= 3);
      #1;
      stalled = M_stall_o;
      if (M_stall_o) stallCycles++;
      if (DMemWReq_o && DMemWReady_i) accepts++;
      @(posedge clk_i);
      #1;
      if (stalled) checkOutput($sformatf("dly_bubble%0d", c), 64'(MW_nop_o), 64'd1);
      else done = 1'b1;
    end
    checkOutput("dly_finished", 64'(done), 64'd1);
    checkOutput("dly_stall_cycles", 64'(stallCycles), 64'd3);
    checkOutput("dly_accepts", 64'(accepts), 64'd1);
    checkOutput("dly_mwpc", 64'(MW_PC_o), 64'h400);
    checkOutput("dly_mwnop", 64'(MW_nop_o), 64'd0);

    // Store acknowledged while M_stall_i holds it for four cycles: written exactly once
    cur = make_instr(K_STORE, 3'b011, 32'h2008, 0, 64'h0BAD_F00D_1234_5678, 0, 0, 0, 6'd0, 1'b0, 32'h500);
    applyStimulus(cur, 1'b1, 1'b1, 1'b0);
    accepts = 0; reqLate = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (DMemWReq_o && DMemWReady_i) accepts++;
      if (c > 0 && DMemWReq_o) reqLate++;
      @(posedge clk_i);
      #1;
      checkOutput($sformatf("hold_pc%0d", c), 64'(MW_PC_o), 64'h400);
    end
    @(negedge clk_i);
    M_stall_i = 1'b0;
    #1;
    checkOutput("hold_release_req", 64'(DMemWReq_o), 64'd0);
    if (DMemWReq_o && DMemWReady_i) accepts++;
    @(posedge clk_i);
    #1;
    checkOutput("hold_accepts", 64'(accepts), 64'd1);
    checkOutput("hold_req_late", 64'(reqLate), 64'd0);
    checkOutput("hold_mwpc", 64'(MW_PC_o), 64'h500);
    alu = make_instr(K_ALU, 3'b000, 0, 0, 0, 64'h77, 0, 0, 6'd4, 1'b1, 32'h580);
    checkInstr(alu, 64'h77, 8'h00, 64'h0, "hold_next");

    // Watchdog: ready never comes; stall drops at cnt == MAX_WAIT and the fault pulses once
    cur = make_instr(K_STORE, 3'b010, 32'h3008, 0, 64'h1111, 0, 0, 0, 6'd0, 1'b0, 32'h600);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    stallCycles = 0; faults = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (M_stall_o) stallCycles++;
      else done = 1'b1;
      if (M_fault_o) faults++;
      @(posedge clk_i);
      #1;
    end
    checkOutput("wd_released", 64'(done), 64'd1);
    checkOutput("wd_stall_cycles", 64'(stallCycles), 64'd4);
    checkOutput("wd_early_fault", 64'(faults), 64'd0);
    checkOutput("wd_fault_pulse", 64'(M_fault_o), 64'd1);
    checkOutput("wd_store_retired", 64'(MW_PC_o), 64'h600);
    alu = make_instr(K_ALU, 3'b000, 0, 0, 0, 64'h99, 0, 0, 6'd2, 1'b1, 32'h700);
    checkInstr(alu, 64'h99, 8'h00, 64'h0, "wd_next");
    checkOutput("wd_fault_cleared", 64'(M_fault_o), 64'd0);

    // Reset in the middle of WAIT abandons the write with no fault pulse
    cur = make_instr(K_STORE, 3'b010, 32'h300C, 0, 64'h2222, 0, 0, 0, 6'd0, 1'b0, 32'h800);
    applyStimulus(cur, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    checkOutput("rstw_req", 64'(DMemWReq_o), 64'd0);
    @(posedge clk_i);
    #1;
    checkOutput("rstw_fault", 64'(M_fault_o), 64'd0);
    checkOutput("rstw_nop", 64'(MW_nop_o), 64'd1);
    checkOutput("rstw_instr", 64'(MW_instr_o), 64'h33);
    @(negedge clk_i);
    reset_i = 1'b0;
    driveNop();
    faults = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i);
      #1;
      if (M_fault_o) faults++;
    end
    checkOutput("rstw_no_fault", 64'(faults), 64'd0);
    alu = make_instr(K_ALU, 3'b000, 0, 0, 0, 64'h123, 0, 0, 6'd1, 1'b1, 32'h880);
    checkInstr(alu, 64'h123, 8'h00, 64'h0, "rstw_next");

    // CSR write held by M_stall_i, then released, then the same CSR flushed
    cur = make_instr(K_CSR, 3'b001, 0, 0, 0, 64'h5, 32'hA, 12'h300, 6'd5, 1'b1, 32'h900);
    applyStimulus(cur, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("csr_held_en", 64'(csrWEnable_o), 64'd0);
    @(posedge clk_i);
    #1;
    checkOutput("csr_held_mwpc", 64'(MW_PC_o), 64'h880);
    @(negedge clk_i);
    M_stall_i = 1'b0;
    #1;
    checkOutput("csr_rel_en", 64'(csrWEnable_o), 64'd1);
    checkOutput("csr_rel_data", 64'(csrWData_o), 64'h5);
    @(posedge clk_i);
    #1;
    checkOutput("csr_rel_wb", MW_wbData_o, 64'hFFFFFFFF_0000000A);
    checkOutput("csr_rel_wben", 64'(MW_wbEnable_o), 64'd1);
    cur.pc = 32'h904;
    applyStimulus(cur, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("csr_flush_en", 64'(csrWEnable_o), 64'd1);
    @(posedge clk_i);
    #1;
    checkOutput("csr_flush_wben", 64'(MW_wbEnable_o), 64'd0);
    checkOutput("csr_flush_nop", 64'(MW_nop_o), 64'd1);
    checkOutput("csr_flush_instr", 64'(MW_instr_o), 64'h33);
    @(negedge clk_i);
    W_flush_i = 1'b0;
    driveNop();
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
